// File: rtl/mmu_sequencer_pkg.sv
// Shared types and width helpers for the systolic-array MMU sequencer.
// Holds the sequencer state enumeration, the default parameter values and
// the functions that derive address, lane-index and beat-count widths.
package mmu_sequencer_pkg;

  localparam int unsigned DEF_N        = 2;
  localparam int unsigned DEF_ACC_W    = 16;
  localparam int unsigned DEF_OUT_W    = 8;
  localparam int unsigned DEF_PIPE_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  // Operand memory holds both A and B: 2*N*N words.
  function automatic int unsigned calc_aw(input int unsigned n);
    return $clog2(2 * n * n);
  endfunction

  // Per-lane operand index width, never narrower than one bit.
  function automatic int unsigned calc_iw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Host beats needed to carry one accumulator result.
  function automatic int unsigned calc_bpr(input int unsigned acc_w, input int unsigned out_w);
    return acc_w / out_w;
  endfunction

endpackage

// File: rtl/mmu_sequencer_result_serializer.sv
// Snapshots the array results and streams them to the host as OUT_W beats,
// row-major by element, most significant slice first.
// Ports: load (capture c_flat and present the first beat), c_flat,
//        out_data/out_valid/out_ready (host stream), last_c (final beat is
//        being accepted this cycle), done (pulse after the final accept).
module result_serializer
  import mmu_sequencer_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [N*N*ACC_W-1:0]   c_flat,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   last_c,
  output logic                   done
);

  localparam int unsigned BPR = calc_bpr(ACC_W, OUT_W);
  localparam int unsigned EW  = $clog2(N * N);
  localparam int unsigned SW  = (BPR < 2) ? 1 : $clog2(BPR);

  logic [N*N*ACC_W-1:0] snap_q;
  logic [EW-1:0]        elem_q, elem_d;
  logic [SW-1:0]        slc_q, slc_d;
  logic                 accept_c;

  // Slice s of element e; slice BPR-1 is the most significant.
  function automatic logic [OUT_W-1:0] pick(input logic [N*N*ACC_W-1:0] v,
                                            input logic [EW-1:0] e,
                                            input logic [SW-1:0] s);
    return v[(int'(e) * int'(ACC_W) + int'(s) * int'(OUT_W)) +: OUT_W];
  endfunction

  assign accept_c = out_valid && out_ready;
  assign last_c   = accept_c && (elem_q == EW'(N * N - 1)) && (slc_q == '0);

  // Beat position following the current one.
  always_comb begin
    elem_d = elem_q;
    slc_d  = slc_q;
    if (slc_q == '0) begin
      elem_d = elem_q + EW'(1);
      slc_d  = SW'(BPR - 1);
    end else begin
      slc_d = slc_q - SW'(1);
    end
  end

  // Snapshot, beat counters and registered beat output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q    <= '0;
      elem_q    <= '0;
      slc_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        snap_q    <= c_flat;
        elem_q    <= '0;
        slc_q     <= SW'(BPR - 1);
        out_valid <= 1'b1;
        out_data  <= pick(c_flat, EW'(0), SW'(BPR - 1));
      end else if (accept_c) begin
        if (last_c) begin
          out_valid <= 1'b0;
          out_data  <= '0;
          done      <= 1'b1;
        end else begin
          elem_q   <= elem_d;
          slc_q    <= slc_d;
          out_data <= pick(snap_q, elem_d, slc_d);
        end
      end
    end
  end

endmodule

// File: rtl/mmu_sequencer.sv
// Job sequencer for an N x N systolic matrix unit: loads 2*N*N operand
// words, drives the skewed operand feed, waits for the array pipeline and
// drains the results to the host.
// Ports: load_en/transpose (operand load), mem_addr (write address),
//        clear/feed_valid/a_sel/b_sel/a_vld/b_vld (array feed control),
//        transpose_out (job mode), c_flat (array results),
//        out_data/out_valid/out_ready (result stream), busy, done.
module mmu_sequencer
  import mmu_sequencer_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned OUT_W    = DEF_OUT_W,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
  localparam int unsigned AW      = calc_aw(N),
  localparam int unsigned IW      = calc_iw(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic                 transpose,
  input  logic [N*N*ACC_W-1:0] c_flat,
  input  logic                 out_ready,
  output logic [AW-1:0]        mem_addr,
  output logic                 clear,
  output logic                 feed_valid,
  output logic [N*IW-1:0]      a_sel,
  output logic [N*IW-1:0]      b_sel,
  output logic [N-1:0]         a_vld,
  output logic [N-1:0]         b_vld,
  output logic                 transpose_out,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned WORDS = 2 * N * N;
  localparam int unsigned PL    = (PIPE_LAT == 0) ? 1 : PIPE_LAT;
  localparam int unsigned CW    = $clog2(3 * N + PL);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_d;
  logic             trans_d;
  logic             clear_d;
  logic             feed_d;
  logic             busy_d;
  logic [N-1:0]     vld_d;
  logic [N*IW-1:0]  sel_d;
  logic             snap_load_c;
  logic             drain_last_c;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_addr      <= '0;
      transpose_out <= 1'b0;
      clear         <= 1'b0;
      feed_valid    <= 1'b0;
      a_vld         <= '0;
      b_vld         <= '0;
      a_sel         <= '0;
      b_sel         <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_addr      <= addr_d;
      transpose_out <= trans_d;
      clear         <= clear_d;
      feed_valid    <= feed_d;
      a_vld         <= vld_d;
      b_vld         <= vld_d;
      a_sel         <= sel_d;
      b_sel         <= sel_d;
      busy          <= busy_d;
    end
  end

  // Next state, counters and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = mem_addr;
    trans_d     = transpose_out;
    snap_load_c = 1'b0;
    vld_d       = '0;
    sel_d       = '0;

    case (state_q)
      ST_IDLE: begin
        // The triggering beat is written at address 0.
        if (load_en) begin
          addr_d  = AW'(1);
          trans_d = transpose;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_en) begin
          if (mem_addr == AW'(WORDS - 1)) begin
            addr_d  = '0;
            cnt_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            addr_d = mem_addr + AW'(1);
          end
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == CW'(3 * N - 3)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(PL - 1)) begin
          snap_load_c = 1'b1;
          state_d     = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    feed_d  = (state_d == ST_COMPUTE);
    clear_d = feed_d && (state_q != ST_COMPUTE);
    busy_d  = (state_d != ST_IDLE);

    // Lane i carries operand k = t - i while 0 <= k < N.
    for (int i = 0; i < int'(N); i++) begin
      if (feed_d && (int'(cnt_d) >= i) && (int'(cnt_d) < i + int'(N))) begin
        vld_d[i]           = 1'b1;
        sel_d[i*IW +: IW]  = IW'(int'(cnt_d) - i);
      end
    end
  end

  result_serializer #(
    .N     (N),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (snap_load_c),
    .c_flat    (c_flat),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last_c    (drain_last_c),
    .done      (done)
  );

endmodule

// File: tb/tb_mmu_sequencer.sv
module tb_mmu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // N=2 instance
  logic        load_en, transpose, out_ready;
  logic [63:0] cf;
  logic [2:0]  mem_addr;
  logic        clear, feed_valid, transpose_out, out_valid, busy, done;
  logic [1:0]  a_sel, b_sel, a_vld, b_vld;
  logic [7:0]  out_data;

  // N=4, ACC_W=32 instance
  logic         le4, tr4, rdy4;
  logic [511:0] cf4;
  logic [4:0]   addr4;
  logic         clr4, fv4, to4, ov4, busy4, done4;
  logic [7:0]   as4, bs4;
  logic [3:0]   av4, bv4;
  logic [7:0]   od4;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] CF  = 64'h0708_0506_0304_0102;
  localparam logic [63:0] CF2 = 64'hDEAD_BEEF_CAFE_F00D;

  mmu_sequencer #(.N(2), .ACC_W(16), .OUT_W(8), .PIPE_LAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .transpose(transpose),
    .c_flat(cf), .out_ready(out_ready), .mem_addr(mem_addr), .clear(clear),
    .feed_valid(feed_valid), .a_sel(a_sel), .b_sel(b_sel), .a_vld(a_vld),
    .b_vld(b_vld), .transpose_out(transpose_out), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  mmu_sequencer #(.N(4), .ACC_W(32), .OUT_W(8), .PIPE_LAT(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_en(le4), .transpose(tr4),
    .c_flat(cf4), .out_ready(rdy4), .mem_addr(addr4), .clear(clr4),
    .feed_valid(fv4), .a_sel(as4), .b_sel(bs4), .a_vld(av4),
    .b_vld(bv4), .transpose_out(to4), .out_data(od4),
    .out_valid(ov4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic        le, tr, rdy;
    logic [63:0] c;
    logic [2:0]  addr;
    logic        clr, fv;
    logic [1:0]  av, as;
    logic        bsy, ov;
    logic [7:0]  od;
    logic        dn, to;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(logic le, logic tr, logic rdy, logic [63:0] c,
                               logic [2:0] addr, logic clr, logic fv,
                               logic [1:0] av, logic [1:0] as, logic bsy,
                               logic ov, logic [7:0] od, logic dn, logic to);
    vec_t v;
    v.le = le; v.tr = tr; v.rdy = rdy; v.c = c; v.addr = addr; v.clr = clr;
    v.fv = fv; v.av = av; v.as = as; v.bsy = bsy; v.ov = ov; v.od = od;
    v.dn = dn; v.to = to;
    return v;
  endfunction

  function automatic logic [31:0] pack_exp(vec_t v);
    return {7'd0, v.addr, v.clr, v.fv, v.av, v.as, v.av, v.as, v.bsy, v.ov, v.od, v.dn, v.to};
  endfunction

  function automatic logic [31:0] pack_act();
    return {7'd0, mem_addr, clear, feed_valid, a_vld, a_sel, b_vld, b_sel,
            busy, out_valid, out_data, done, transpose_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load8(input logic tr);
    for (int i = 0; i < 8; i++) begin
      load_en = 1'b1;
      transpose = (i == 0) ? tr : ~tr;
      tick();
    end
    load_en = 1'b0;
    transpose = 1'b0;
  endtask

  task automatic wait_ov(input string name);
    int g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    load_en = 0; transpose = 0; out_ready = 0; cf = CF;
    le4 = 0; tr4 = 0; rdy4 = 0; cf4 = '0;
    for (int e = 0; e < 16; e++)
      for (int b = 0; b < 4; b++)
        cf4[e*32 + (3-b)*8 +: 8] = 8'(e*4 + b);

    #12;
    check("reset_n2", 64'(pack_act()), 64'd0);
    check("reset_n4", {7'd0, addr4, clr4, fv4, as4, bs4, av4, bv4, to4, od4, ov4, busy4, done4},
          64'd0);
    rst_n = 1'b1;

    // Job 1: load, skewed feed, wait, full drain.
    //               le tr rdy c    addr clr fv av     as     bsy ov od     dn to
    tbl.push_back(row(1, 1, 0, CF,  1,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  2,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(0, 1, 0, CF,  2,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  3,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  4,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  5,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  6,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  7,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  0,  1, 1, 2'b01, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(1, 0, 0, CF,  0,  0, 1, 2'b11, 2'b01, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(0, 0, 0, CF,  0,  0, 1, 2'b10, 2'b10, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(0, 0, 0, CF,  0,  0, 1, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(0, 0, 0, CF,  0,  0, 0, 2'b00, 2'b00, 1, 0, 8'h00, 0, 1));
    tbl.push_back(row(0, 0, 0, CF,  0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h01, 0, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h02, 0, 1));
    tbl.push_back(row(1, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h03, 0, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h04, 0, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h05, 0, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h06, 0, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h07, 0, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 1, 1, 8'h08, 0, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 0, 0, 8'h00, 1, 1));
    tbl.push_back(row(0, 0, 1, CF2, 0,  0, 0, 2'b00, 2'b00, 0, 0, 8'h00, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      load_en = tbl[i].le; transpose = tbl[i].tr; out_ready = tbl[i].rdy; cf = tbl[i].c;
      tick();
      check($sformatf("row%0d", i), 64'(pack_act()), 64'(pack_exp(tbl[i])));
    end
    load_en = 0; out_ready = 0; cf = CF;

    // Job 2: three-cycle stall on beat 3 while c_flat keeps changing.
    load8(1'b0);
    check("job2_transpose", 64'(transpose_out), 64'd0);
    wait_ov("job2_drain_start");
    check("job2_beat1", 64'(out_data), 64'h01);
    out_ready = 1; cf = CF2;
    tick(); check("job2_beat2", 64'(out_data), 64'h02);
    tick(); check("job2_beat3", 64'(out_data), 64'h03);
    out_ready = 0;
    for (int s = 0; s < 3; s++) begin
      cf = {$urandom, $urandom};
      tick();
      check($sformatf("job2_stall%0d", s), {out_valid, out_data}, {1'b1, 8'h03});
    end
    out_ready = 1;
    for (int b = 4; b <= 8; b++) begin
      tick();
      check($sformatf("job2_beat%0d", b), 64'(out_data), 64'(b));
    end
    tick();
    check("job2_done", {done, out_valid}, {1'b1, 1'b0});
    out_ready = 0; cf = CF;

    // Job 3: reset during beat 5 abandons the job.
    load8(1'b0);
    wait_ov("job3_drain_start");
    out_ready = 1;
    repeat (4) tick();
    check("job3_beat5", 64'(out_data), 64'h05);
    rst_n = 0;
    #1;
    check("job3_reset", {out_valid, busy, done, out_data, mem_addr}, 64'd0);
    out_ready = 0;
    repeat (2) begin
      tick();
      check("job3_no_done_rst", {done, busy}, 64'd0);
    end
    rst_n = 1;
    repeat (3) begin
      tick();
      check("job3_no_done_idle", {done, busy, out_valid}, 64'd0);
    end

    // Job 4: normal job after the abandoned one.
    load8(1'b1);
    check("job4_transpose", 64'(transpose_out), 64'd1);
    wait_ov("job4_drain_start");
    out_ready = 1;
    begin
      int beats = 0;
      int g = 0;
      while (out_valid && g < 30) begin
        check($sformatf("job4_beat%0d", beats + 1), 64'(out_data), 64'(beats + 1));
        tick();
        beats++;
        g++;
      end
      check("job4_beats", 64'(beats), 64'd8);
      check("job4_done", 64'(done), 64'd1);
    end
    out_ready = 0;

    // N=4, ACC_W=32: 10 feed cycles, 64 beats, load_en ignored in DRAIN.
    begin
      int n = 0;
      int beats = 0;
      int g = 0;
      le4 = 1;
      repeat (32) tick();
      le4 = 0;
      check("n4_clear", {clr4, fv4, addr4}, {1'b1, 1'b1, 5'd0});
      while (fv4 && n < 40) begin
        n++;
        tick();
      end
      check("n4_compute_len", 64'(n), 64'd10);
      le4 = 1;
      while (!ov4 && g < 10) begin
        tick();
        g++;
      end
      check("n4_drain_start", 64'(ov4), 64'd1);
      rdy4 = 1;
      g = 0;
      while (ov4 && g < 200) begin
        check($sformatf("n4_beat%0d", beats), 64'(od4), 64'(beats));
        tick();
        beats++;
        g++;
      end
      le4 = 0;
      rdy4 = 0;
      check("n4_beats", 64'(beats), 64'd64);
      check("n4_done", {done4, busy4, addr4}, {1'b1, 1'b0, 5'd0});
      tick();
      check("n4_idle", {done4, busy4, ov4}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
